fetch_unit: RTL and testbench

//  Fetch stage of the 16-bit multi-cycle CPU: owns the PC and the instruction register (IR).

---
 rtl/cpu_defs_pkg.sv | 24 ++
 rtl/pc_next_logic.sv | 44 ++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs_pkg
// Description : Shared definitions for the 16-bit multi-cycle CPU: datapath
//               width, fetch FSM state codes and pc_sel codes.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs_pkg;

    localparam int DATA_W = 16;

    // Fetch FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Next-PC selection codes presented by decode
    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b01;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b10;
    localparam logic [1:0] PC_SEL_RSVD   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/pc_next_logic.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_logic
// Description : Combinational next-PC mux. Produces pc+PC_STEP at the end of
//               a fetch, otherwise the decode-selected target (sequential,
//               absolute jump, or PC-relative taken branch).
// Ports       : pc          - current program counter
//               shifted_in  - shifted immediate from left_shift_4
//               pc_sel      - target select (seq / jump / branch / reserved)
//               br_taken    - branch condition
//               fetch_done  - 1: advance by PC_STEP, 0: apply pc_sel
//               next_pc     - candidate new PC value
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_logic
    import cpu_defs_pkg::*;
#(
    parameter int                DW      = DATA_W,
    parameter logic [DW-1:0]     PC_STEP = 16'd2
) (
    input  logic [DW-1:0] pc,
    input  logic [DW-1:0] shifted_in,
    input  logic [1:0]    pc_sel,
    input  logic          br_taken,
    input  logic          fetch_done,
    output logic [DW-1:0] next_pc
);

    always_comb begin
        next_pc = pc;
        if (fetch_done) begin
            next_pc = pc + PC_STEP;
        end else begin
            case (pc_sel)
                PC_SEL_JUMP:   next_pc = shifted_in;
                PC_SEL_BRANCH: next_pc = br_taken ? (pc + shifted_in) : pc;
                // Sequential: pc was already advanced when the fetch completed.
                default:       next_pc = pc;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Fetch stage. Owns PC and IR, runs a req/ack instruction
//               fetch, exports IR[IMM_W-1:0] to the shifter and applies
//               jump/branch targets formed from the shifter result.
// Ports       : clk, reset       - clock, async active-high reset
//               fetch_en         - request next fetch (level)
//               mem_req/mem_addr - instruction memory request and address
//               mem_ack/mem_rdata- memory response
//               ir, ir_valid     - instruction register and its valid flag
//               imm_out          - immediate field to left_shift_4
//               shifted_in       - left_shift_4 result
//               pc_upd/pc_sel/br_taken - decode PC update strobe and controls
//               pc               - current program counter
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu_defs_pkg::*;
#(
    parameter int                  DW       = DATA_W,
    parameter int                  IMM_W    = 12,
    parameter logic [DW-1:0]       RESET_PC = 16'h0000,
    parameter logic [DW-1:0]       PC_STEP  = 16'd2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_en,
    output logic             mem_req,
    output logic [DW-1:0]    mem_addr,
    input  logic             mem_ack,
    input  logic [DW-1:0]    mem_rdata,
    output logic [DW-1:0]    ir,
    output logic             ir_valid,
    output logic [IMM_W-1:0] imm_out,
    input  logic [DW-1:0]    shifted_in,
    input  logic             pc_upd,
    input  logic [1:0]       pc_sel,
    input  logic             br_taken,
    output logic [DW-1:0]    pc
);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          fetch_done;
    logic          pc_load;
    logic [DW-1:0] next_pc;

    // Only acks inside FETCH and decode strobes inside HOLD have any effect.
    assign fetch_done = (state == ST_FETCH) && mem_ack;
    assign pc_load    = fetch_done || ((state == ST_HOLD) && pc_upd);

    pc_next_logic #(
        .DW      (DW),
        .PC_STEP (PC_STEP)
    ) u_pc_next (
        .pc         (pc),
        .shifted_in (shifted_in),
        .pc_sel     (pc_sel),
        .br_taken   (br_taken),
        .fetch_done (fetch_done),
        .next_pc    (next_pc)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (fetch_en) state_nxt = ST_FETCH;
            ST_FETCH: if (mem_ack)  state_nxt = ST_HOLD;
            ST_HOLD:  if (pc_upd)   state_nxt = fetch_en ? ST_FETCH : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic; mem_addr tracks pc, which cannot change during FETCH
    // until the ack edge, so the address is stable for the whole request.
    always_comb begin
        mem_req  = (state == ST_FETCH);
        ir_valid = (state == ST_HOLD);
        mem_addr = pc;
    end

    // PC and IR datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
            ir <= '0;
        end else begin
            if (pc_load) begin
                pc <= next_pc;
            end
            if (fetch_done) begin
                ir <= mem_rdata;
            end
        end
    end

    assign imm_out = ir[IMM_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: directed scenarios then
//               randomized traffic, compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] ir;
    logic        ir_valid;
    logic [11:0] imm_out;
    logic [15:0] shifted_in = '0;
    logic        pc_upd = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic        br_taken = 1'b0;
    logic [15:0] pc;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: "waiting" = a memory read is outstanding,
    // "have_instr" = an instruction sits unconsumed in IR.
    bit          m_waiting;
    bit          m_have_instr;
    logic [15:0] m_pc;
    logic [15:0] m_ir;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_en   (fetch_en),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .imm_out    (imm_out),
        .shifted_in (shifted_in),
        .pc_upd     (pc_upd),
        .pc_sel     (pc_sel),
        .br_taken   (br_taken),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".mem_req"},  {15'd0, mem_req},  {15'd0, m_waiting});
        check({where, ".mem_addr"}, mem_addr, m_pc);
        check({where, ".pc"},       pc, m_pc);
        check({where, ".ir"},       ir, m_ir);
        check({where, ".ir_valid"}, {15'd0, ir_valid}, {15'd0, m_have_instr});
        check({where, ".imm_out"},  {4'd0, imm_out}, {4'd0, m_ir[11:0]});
    endtask

    task automatic model_reset();
        m_waiting = 0; m_have_instr = 0; m_pc = 16'h0000; m_ir = 16'h0000;
    endtask

    // Advance model by one clock using the inputs currently applied.
    task automatic model_clock();
        if (m_waiting) begin
            if (mem_ack) begin
                m_ir = mem_rdata;
                m_pc = m_pc + 16'd2;
                m_waiting = 0;
                m_have_instr = 1;
            end
        end else if (m_have_instr) begin
            if (pc_upd) begin
                if (pc_sel == 2'b01)
                    m_pc = shifted_in;
                else if (pc_sel == 2'b10 && br_taken)
                    m_pc = m_pc + shifted_in;
                m_have_instr = 0;
                m_waiting = fetch_en;
            end
        end else if (fetch_en) begin
            m_waiting = 1;
        end
    endtask

    task automatic step(input string where);
        model_clock();
        @(posedge clk);
        #1;
        check_all(where);
    endtask

    task automatic idle_inputs();
        fetch_en = 0; mem_ack = 0; pc_upd = 0; pc_sel = 2'b00; br_taken = 0;
    endtask

    // Complete the outstanding fetch with the given word.
    task automatic ack_with(input string where, input logic [15:0] word);
        mem_ack = 1; mem_rdata = word;
        step(where);
        mem_ack = 0;
    endtask

    task automatic decode(input string where, input logic [1:0] sel, input logic [15:0] sh,
                          input logic taken, input logic fen);
        pc_upd = 1; pc_sel = sel; shifted_in = sh; br_taken = taken; fetch_en = fen;
        step(where);
        pc_upd = 0; fetch_en = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        check_all("reset");

        // 1: async reset mid-FETCH, then a late ack
        fetch_en = 1;
        step("t1.enter_fetch");
        fetch_en = 0;
        step("t1.wait");
        #2;
        reset = 1;
        model_reset();
        #1;
        check_all("t1.async_reset");
        @(negedge clk);
        reset = 0;
        mem_ack = 1; mem_rdata = 16'hDEAD;
        step("t1.late_ack");
        mem_ack = 0;

        // 2: fetch with three wait cycles
        fetch_en = 1;
        step("t2.req");
        fetch_en = 0;
        repeat (3) step("t2.wait");
        ack_with("t2.ack", 16'hA123);
        check("t2.ir_const", ir, 16'hA123);
        check("t2.pc_const", pc, 16'h0002);
        check("t2.imm_const", {4'd0, imm_out}, 16'h0123);

        // 3: jump to ABC0 while refetching
        decode("t3.seq", 2'b00, 16'h0, 0, 1);
        ack_with("t3.ack", 16'h1ABC);
        decode("t3.jump", 2'b01, 16'hABC0, 0, 1);
        check("t3.mem_addr_const", mem_addr, 16'hABC0);

        // 4: branch taken / not taken from pc=0010
        ack_with("t4.ack0", 16'h0000);
        decode("t4.jmp0", 2'b01, 16'h000E, 0, 1);
        ack_with("t4.ack1", 16'h2000);
        decode("t4.br_taken", 2'b10, 16'h0040, 1, 1);
        check("t4.pc_taken_const", pc, 16'h0050);
        ack_with("t4.ack2", 16'h2000);
        decode("t4.jmp1", 2'b01, 16'h000E, 0, 1);
        ack_with("t4.ack3", 16'h2000);
        decode("t4.br_not", 2'b10, 16'h0040, 0, 1);
        check("t4.pc_not_const", pc, 16'h0010);

        // 5: wraparound on increment and on branch add
        ack_with("t5.ack0", 16'h0000);
        decode("t5.jmp", 2'b01, 16'hFFFE, 0, 1);
        ack_with("t5.wrap_inc", 16'h3000);
        check("t5.pc_wrap_const", pc, 16'h0000);
        decode("t5.jmp2", 2'b01, 16'hEFFE, 0, 1);
        ack_with("t5.ack1", 16'h3000);
        decode("t5.br_wrap", 2'b10, 16'h2000, 1, 1);
        check("t5.br_wrap_const", pc, 16'h1000);

        // 6: release to IDLE, stray ack in IDLE, pc_upd in FETCH
        ack_with("t6.ack", 16'h4321);
        decode("t6.to_idle", 2'b00, 16'h0, 0, 0);
        check("t6.mem_req_const", {15'd0, mem_req}, 16'h0000);
        mem_ack = 1; mem_rdata = 16'hBEEF;
        step("t6.stray_ack");
        idle_inputs();
        fetch_en = 1;
        step("t6.fetch");
        fetch_en = 0;
        pc_upd = 1; pc_sel = 2'b01; shifted_in = 16'h7777;
        step("t6.upd_in_fetch");
        idle_inputs();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            fetch_en   = ($urandom_range(0, 3) != 0);
            mem_ack    = ($urandom_range(0, 2) == 0);
            mem_rdata  = 16'($urandom);
            pc_upd     = ($urandom_range(0, 2) == 0);
            pc_sel     = 2'($urandom);
            shifted_in = {12'($urandom), 4'h0};
            br_taken   = 1'($urandom);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
